sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM Avalon master among four requesters, one transaction at a time.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module sdram_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] req_address,
    input  logic [3:0]   req_read,
    input  logic [3:0]   req_write,
    input  logic [127:0] req_writedata,
    output logic [3:0]   req_waitrequest,
    output logic [31:0]  req_readdata,
    output logic [3:0]   req_readdatavalid,
    input  logic         master_waitrequest,
    output logic [31:0]  master_address,
    output logic         master_read,
    output logic         master_write,
    output logic [31:0]  master_writedata,
    input  logic [31:0]  master_readdata,
    input  logic         master_readdatavalid,
    output logic [3:0]   grant
);
    typedef enum logic [1:0] {IDLE, FWD, WAIT_RD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  req_any, winner;
    logic [1:0]  gidx;
    logic        fwd, g_rd, g_wr, accept, rd_ret;

    assign req_any = req_read | req_write;
    assign gidx    = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
    assign fwd     = state_q == FWD;
    assign g_rd    = req_read[gidx];
    assign g_wr    = req_write[gidx];
    assign accept  = fwd && (g_rd || g_wr) && !master_waitrequest;
    assign rd_ret  = state_q == WAIT_RD && master_readdatavalid;

    // Descending scan so the highest-priority candidate is assigned last.
    always_comb begin
        winner = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--)
            if (req_any[2'(k)]) winner = 4'b1 << 2'(k);
`else
        for (int k = 3; k >= 0; k--)
            if (req_any[ptr_q + 2'(k)]) winner = 4'b1 << (ptr_q + 2'(k));
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    grant_d = winner;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (!(g_rd || g_wr)) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (!master_waitrequest) begin
                    grant_d = g_rd ? grant_q : 4'b0;
                    state_d = g_rd ? WAIT_RD : IDLE;
                    ptr_d   = g_rd ? ptr_q : gidx + 2'd1;
                end
            end
            WAIT_RD: begin
                if (master_readdatavalid) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = gidx + 2'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Command path is combinational from the granted port so a stall holds it in place.
    assign master_read       = fwd && g_rd;
    assign master_write      = fwd && g_wr && !g_rd;
    assign master_address    = fwd ? req_address[{gidx, 5'd0} +: 32] : 32'd0;
    assign master_writedata  = fwd ? req_writedata[{gidx, 5'd0} +: 32] : 32'd0;
    assign req_waitrequest   = ~(accept ? grant_q : 4'b0);
    assign req_readdatavalid = rd_ret ? grant_q : 4'b0;
    assign req_readdata      = rd_ret ? master_readdata : 32'd0;
    assign grant             = grant_q;
endmodule
